tdc_sample_packer: RTL

Downstream stage of the TDC measurement controller. Each time the controller raises its FIFO write enable, this block accepts the 32-bit sample {calib2-calib1, time1} and stores it in an internal FIFO. It acknowledges the sample with a one-cycle fifo_writing_done pulse. It then drains the FIFO as a big-endian byte stream with valid/ready handshake toward the host serial link.

---
 rtl/tdc_sample_packer_if.sv | 29 ++
 rtl/tdc_sample_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_sample_packer_if.sv
//------------------------------------------------------------------------------
// tdc_sample_packer_if
//
// Bundles the two handshakes of the TDC sample packer:
//   - sample write side : wr_en, data_in (to packer), fifo_writing_done (from packer)
//   - byte stream side  : out_data, out_valid (from packer), out_ready (to packer)
//
// Modports:
//   master : the environment (measurement controller + host serial link)
//   slave  : the packer itself
//------------------------------------------------------------------------------
interface tdc_sample_packer_if;
    logic        wr_en;
    logic [31:0] data_in;
    logic        fifo_writing_done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output wr_en, data_in, out_ready,
        input  fifo_writing_done, out_data, out_valid
    );

    modport slave (
        input  wr_en, data_in, out_ready,
        output fifo_writing_done, out_data, out_valid
    );
endinterface

// File: rtl/tdc_sample_packer.sv
//------------------------------------------------------------------------------
// tdc_sample_packer
//
// Accepts 32-bit TDC samples {calib diff, time1} on each rising edge of the
// controller's wr_en, buffers them in a 2**DEPTH_LOG2-word circular FIFO and
// drains them as a big-endian byte stream with a valid/ready handshake.
// Every request (stored or dropped because the FIFO is full) is acknowledged
// by a one-cycle fifo_writing_done pulse one cycle after the request edge.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset, clears all state
//   bus          tdc_sample_packer_if.slave: wr_en, data_in, fifo_writing_done,
//                out_data, out_valid, out_ready
//   flush        synchronous clear of FIFO, serializer and wr_en edge register
//   level        words currently held in the FIFO (excludes the word being
//                serialized)
//   overflow_cnt dropped-sample count, saturating at 16'hFFFF
//
// Configuration:
//   TDC_PACKER_SYNC_EN  when defined, each word is preceded by SYNC_BYTE
//                       (5 bytes per word); otherwise 4 bytes per word.
//------------------------------------------------------------------------------
module tdc_sample_packer #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    tdc_sample_packer_if.slave    bus,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           overflow_cnt
);
    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_B3,
        S_B2,
        S_B1,
        S_B0
    } state_t;

    state_t                  state;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    wr_q;
    logic [31:0]             word_q;
    logic [31:0]             head;
    logic                    req;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    drop;
    logic                    pop;
    logic                    hs;
    state_t                  first_state;
    logic [7:0]              first_byte;

    // Fullness/emptiness come from level at the start of the cycle, so a pop
    // on the same edge never makes room for a push and vice versa.
    assign req   = bus.wr_en & ~wr_q;
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign push  = req & ~full & ~flush;
    assign drop  = req &  full & ~flush;
    assign hs    = bus.out_valid & bus.out_ready;
    assign pop   = ~flush & ~empty & ((state == S_IDLE) | ((state == S_B0) & hs));
    assign head  = mem[rd_ptr];

`ifdef TDC_PACKER_SYNC_EN
    assign first_state = S_SYNC;
    assign first_byte  = SYNC_BYTE;
`else
    assign first_state = S_B3;
    assign first_byte  = head[31:24];
    // SYNC_BYTE has no role without the frame marker; tie it off visibly.
    logic [7:0] unused_sync_byte;
    assign unused_sync_byte = SYNC_BYTE;
`endif

    // NOTE: FIFO storage is deliberately not reset; pointers and level define
    // which entries are valid, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Request edge detection, FIFO bookkeeping and the acknowledge pulse.
    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q                  <= 1'b0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            level                 <= '0;
            overflow_cnt          <= '0;
            bus.fifo_writing_done <= 1'b0;
        end else if (flush) begin
            // A request coinciding with flush is discarded without a done pulse.
            wr_q                  <= 1'b0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            level                 <= '0;
            bus.fifo_writing_done <= 1'b0;
        end else begin
            wr_q                  <= bus.wr_en;
            bus.fifo_writing_done <= req;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // Serializer: out_data/out_valid are registered and only change on a
    // handshake, so they hold steady while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            word_q        <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
        end else if (flush) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        word_q        <= head;
                        bus.out_data  <= first_byte;
                        bus.out_valid <= 1'b1;
                        state         <= first_state;
                    end
                end
                S_SYNC: begin
                    if (hs) begin
                        bus.out_data <= word_q[31:24];
                        state        <= S_B3;
                    end
                end
                S_B3: begin
                    if (hs) begin
                        bus.out_data <= word_q[23:16];
                        state        <= S_B2;
                    end
                end
                S_B2: begin
                    if (hs) begin
                        bus.out_data <= word_q[15:8];
                        state        <= S_B1;
                    end
                end
                S_B1: begin
                    if (hs) begin
                        bus.out_data <= word_q[7:0];
                        state        <= S_B0;
                    end
                end
                S_B0: begin
                    if (hs) begin
                        if (pop) begin
                            // Next word follows immediately, no idle bubble.
                            word_q       <= head;
                            bus.out_data <= first_byte;
                            state        <= first_state;
                        end else begin
                            bus.out_valid <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule
